// File: rtl/cybernid_quant_pkg.sv
// cybernid_quant_pkg: shared constants, FSM state type and the per-feature
// threshold table for the CyberNID input quantizer.
// Optional build macro used by this slice: CYBERNID_LEN_CHECK_EN.
package cybernid_quant_pkg;

  localparam int N_FEAT    = 32;
  localparam int RAW_W     = 16;
  localparam int QBITS     = 2;
  localparam int N_THR     = (1 << QBITS) - 1;
  localparam int ERR_CNT_W = 8;
  localparam int IDX_W     = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FULL    = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // THRESH[feature][k], ascending in k for every feature.
  typedef logic [N_FEAT-1:0][N_THR-1:0][RAW_W-1:0] thresh_t;

  // Threshold table as exported by training; feature 0 is {100,200,300} and
  // later features spread progressively wider so every code is reachable.
  function automatic thresh_t gen_thresh();
    thresh_t t;
    t = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      for (int k = 0; k < N_THR; k++) begin
        t[i][k] = RAW_W'(100 * (k + 1) + 64 * (k + 1) * (k + 1) * i);
      end
    end
    return t;
  endfunction

  localparam thresh_t THRESH = gen_thresh();

endpackage

// File: rtl/cybernid_feat_quant.sv
// cybernid_feat_quant: combinational threshold compare for one raw sample.
// Shared by all features because feature beats arrive serially; the feature
// index selects which threshold row applies.
module cybernid_feat_quant
  import cybernid_quant_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  input  logic [RAW_W-1:0] i_data,
  output logic [QBITS-1:0] o_code
);

  logic [QBITS-1:0] w_code;

  // Code is the number of thresholds the sample reaches or exceeds.
  always_comb begin
    w_code = '0;
    for (int k = 0; k < N_THR; k++) begin
      if (i_data >= THRESH[i_idx][k]) begin
        w_code = w_code + QBITS'(1);
      end else begin
        w_code = w_code;
      end
    end
  end

  assign o_code = w_code;

endmodule

// File: rtl/cybernid_input_quantizer.sv
// cybernid_input_quantizer: collects N_FEAT raw feature beats, quantizes each
// to QBITS via per-feature thresholds and hands the packed vector to layer 0.
// Optional macro CYBERNID_LEN_CHECK_EN enables s_last framing checks (short /
// long frame detection, DRAIN state, frame_err pulse and err_cnt counter).
// Without it s_last is ignored and the frame boundary is purely the count.
module cybernid_input_quantizer
  import cybernid_quant_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [RAW_W-1:0]          s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [N_FEAT*QBITS-1:0]   m_feat,
  output logic                      frame_err,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx_nxt;
  logic                      r_s_ready;
  logic                      r_m_valid;
  logic [N_FEAT*QBITS-1:0]   r_feat;
  logic [QBITS-1:0]          w_code;
  logic                      w_accept;
  logic                      w_wr_slot;
  logic                      w_err;

  assign w_accept = s_valid && r_s_ready;

  cybernid_feat_quant u_feat_quant (
    .i_idx  (r_idx),
    .i_data (s_data),
    .o_code (w_code)
  );

  // Next-state, index advance, slot-write and framing-error decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr_slot   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_accept) begin
`ifdef CYBERNID_LEN_CHECK_EN
          if (s_last && (r_idx != LAST_IDX)) begin
            // Short frame: discard this beat and restart collection.
            w_idx_nxt = '0;
            w_err     = 1'b1;
          end else if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (s_last) begin
              w_wr_slot   = 1'b1;
              w_state_nxt = ST_FULL;
            end else begin
              // Long frame: drop it and swallow beats up to s_last.
              w_err       = 1'b1;
              w_state_nxt = ST_DRAIN;
            end
          end else begin
            w_wr_slot = 1'b1;
            w_idx_nxt = r_idx + IDX_W'(1);
          end
`else
          w_wr_slot = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_FULL;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
`endif
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_FULL: begin
        if (m_ready) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DRAIN: begin
`ifdef CYBERNID_LEN_CHECK_EN
        if (w_accept && s_last) begin
          w_state_nxt = ST_COLLECT;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = r_state;
        end
`else
        w_state_nxt = ST_COLLECT;
        w_idx_nxt   = '0;
`endif
      end
      default: begin
        w_state_nxt = ST_COLLECT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State, index and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_COLLECT;
      r_idx     <= '0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_s_ready <= (w_state_nxt != ST_FULL);
      r_m_valid <= (w_state_nxt == ST_FULL);
    end
  end

  // Packed code vector; only the slot addressed by idx is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat <= '0;
    end else begin
      for (int s = 0; s < N_FEAT; s++) begin
        if (w_wr_slot && (r_idx == IDX_W'(s))) begin
          r_feat[s*QBITS +: QBITS] <= w_code;
        end
      end
    end
  end

`ifdef CYBERNID_LEN_CHECK_EN
  logic                 r_frame_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Framing-error pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;
`else
  logic w_unused;
  assign w_unused  = s_last | w_err;
  assign frame_err = 1'b0;
  assign err_cnt   = '0;
`endif

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_feat  = r_feat;

endmodule

// File: tb/tb_cybernid_input_quantizer.sv
// tb_cybernid_input_quantizer: randomized self-checking bench for the CyberNID
// input quantizer. Build with CYBERNID_LEN_CHECK_EN to add the framing tests.
module tb_cybernid_input_quantizer;
  import cybernid_quant_pkg::*;

  localparam int VW = N_FEAT * QBITS;

  typedef logic [RAW_W-1:0] frame_t [N_FEAT];

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 s_valid;
  logic                 s_ready;
  logic [RAW_W-1:0]     s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [VW-1:0]        m_feat;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  cybernid_input_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_feat    (m_feat),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  // Reference quantizer: first threshold the value falls below gives the code.
  function automatic int ref_code(int f, logic [RAW_W-1:0] v);
    for (int k = 0; k < N_THR; k++) begin
      if (v < THRESH[f][k]) return k;
    end
    return N_THR;
  endfunction

  function automatic logic [VW-1:0] ref_vec(frame_t d);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N_FEAT; i++) v[i*QBITS +: QBITS] = QBITS'(ref_code(i, d[i]));
    return v;
  endfunction

  task automatic rand_frame(output frame_t d);
    for (int i = 0; i < N_FEAT; i++) begin
      if ($urandom_range(0, 3) == 0) d[i] = RAW_W'($urandom);
      else d[i] = RAW_W'($urandom_range(0, int'(THRESH[i][N_THR-1]) + 50));
    end
  endtask

  // Drive one beat and return #1 after the edge on which it was accepted.
  task automatic send_beat(input logic [RAW_W-1:0] d, input logic last, input bit gap);
    int n;
    n = 0;
    while (gap && ($urandom_range(0, 1) == 1) && (n < 8)) begin
      s_valid = 1'b0;
      s_data  = RAW_W'($urandom);
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && (n < 200)) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout s_ready=%0b required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input frame_t d, input bit gap);
    for (int i = 0; i < N_FEAT; i++) send_beat(d[i], (i == N_FEAT - 1), gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b exp 0", m_valid); end
    checks++; if (m_feat !== '0) begin errors++; $display("FAIL reset_m_feat got %h exp 0", m_feat); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b exp 0", frame_err); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0b exp 1", s_ready); end
    exp_err = 0;
  endtask

  task automatic test_quant_points();
    logic [RAW_W-1:0] pts [4];
    logic [1:0]       exp [4];
    frame_t           d;
    pts = '{16'd99, 16'd100, 16'd299, 16'd65535};
    exp = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int p = 0; p < 4; p++) begin
      rand_frame(d);
      d[0] = pts[p];
      send_frame(d, 1'b0);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL qp_m_valid p=%0d got %0b exp 1", p, m_valid); end
      checks++; if (m_feat[1:0] !== exp[p]) begin errors++; $display("FAIL qp_code v=%0d got %0d exp %0d", pts[p], m_feat[1:0], exp[p]); end
      checks++; if (m_feat !== ref_vec(d)) begin errors++; $display("FAIL qp_vec got %h exp %h", m_feat, ref_vec(d)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_frame();
    frame_t d;
    for (int i = 0; i < N_FEAT; i++) d[i] = RAW_W'(i * 10);
    m_ready = 1'b1;
    for (int i = 0; i < N_FEAT - 1; i++) begin
      send_beat(d[i], 1'b0, 1'b0);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ff_early_m_valid beat=%0d got %0b exp 0", i, m_valid); end
    end
    send_beat(d[N_FEAT-1], 1'b1, 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ff_latency got %0b exp 1", m_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL ff_s_ready_low got %0b exp 0", s_ready); end
    checks++; if (m_feat !== ref_vec(d)) begin errors++; $display("FAIL ff_vec got %h exp %h", m_feat, ref_vec(d)); end
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ff_s_ready_back got %0b exp 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ff_m_valid_drop got %0b exp 0", m_valid); end
  endtask

  task automatic test_stall();
    frame_t        d;
    logic [VW-1:0] exp;
    rand_frame(d);
    exp = ref_vec(d);
    m_ready = 1'b0;
    send_frame(d, 1'b0);
    for (int c = 0; c < 20; c++) begin
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_m_valid c=%0d got %0b exp 1", c, m_valid); end
      checks++; if (m_feat !== exp) begin errors++; $display("FAIL stall_m_feat c=%0d got %h exp %h", c, m_feat, exp); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready c=%0d got %0b exp 0", c, s_ready); end
      s_data = RAW_W'($urandom);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_release_m_valid got %0b exp 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stall_release_s_ready got %0b exp 1", s_ready); end
  endtask

  task automatic test_gaps();
    frame_t d;
    m_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_frame(d);
      send_frame(d, 1'b1);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL gap_m_valid f=%0d got %0b exp 1", f, m_valid); end
      checks++; if (m_feat !== ref_vec(d)) begin errors++; $display("FAIL gap_vec f=%0d got %h exp %h", f, m_feat, ref_vec(d)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    frame_t d;
    // Reset while a vector is waiting in FULL.
    rand_frame(d);
    m_ready = 1'b0;
    send_frame(d, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstfull_m_valid got %0b exp 0", m_valid); end
    checks++; if (m_feat !== '0) begin errors++; $display("FAIL rstfull_m_feat got %h exp 0", m_feat); end
    @(negedge clk) rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    // Reset after beat 15 of a frame.
    rand_frame(d);
    for (int i = 0; i < 16; i++) send_beat(d[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (m_feat !== '0) begin errors++; $display("FAIL rstmid_m_feat got %h exp 0", m_feat); end
    checks++; if ((m_valid !== 1'b0) || (frame_err !== 1'b0) || (err_cnt !== '0)) begin
      errors++; $display("FAIL rstmid_outputs got v=%0b fe=%0b ec=%0d exp 0", m_valid, frame_err, err_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    exp_err = 0;
    @(posedge clk); #1;
    rand_frame(d);
    send_frame(d, 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_clean_valid got %0b exp 1", m_valid); end
    checks++; if (m_feat !== ref_vec(d)) begin errors++; $display("FAIL rstmid_clean_vec got %h exp %h", m_feat, ref_vec(d)); end
    @(posedge clk); #1;
  endtask

`ifndef CYBERNID_LEN_CHECK_EN
  task automatic test_slast_ignored();
    frame_t d;
    rand_frame(d);
    for (int i = 0; i < N_FEAT; i++) begin
      send_beat(d[i], (i == 10) || ($urandom_range(0, 3) == 0), 1'b0);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL nolen_frame_err beat=%0d got %0b exp 0", i, frame_err); end
    end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL nolen_m_valid got %0b exp 1", m_valid); end
    checks++; if (m_feat !== ref_vec(d)) begin errors++; $display("FAIL nolen_vec got %h exp %h", m_feat, ref_vec(d)); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL nolen_err_cnt got %0d exp 0", err_cnt); end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_short_frame();
    frame_t d;
    rand_frame(d);
    for (int i = 0; i <= 10; i++) begin
      send_beat(d[i], (i == 10), 1'b0);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL short_m_valid beat=%0d got %0b exp 0", i, m_valid); end
    end
    exp_err++;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err got %0b exp 1", frame_err); end
    checks++; if (err_cnt !== ERR_CNT_W'(exp_err)) begin errors++; $display("FAIL short_err_cnt got %0d exp %0d", err_cnt, exp_err); end
    @(posedge clk); #1;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_pulse_width got %0b exp 0", frame_err); end
    rand_frame(d);
    send_frame(d, 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL short_next_valid got %0b exp 1", m_valid); end
    checks++; if (m_feat !== ref_vec(d)) begin errors++; $display("FAIL short_next_vec got %h exp %h", m_feat, ref_vec(d)); end
    checks++; if (err_cnt !== ERR_CNT_W'(exp_err)) begin errors++; $display("FAIL short_next_err_cnt got %0d exp %0d", err_cnt, exp_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_long_frame();
    frame_t d;
    rand_frame(d);
    for (int i = 0; i < 35; i++) begin
      send_beat(RAW_W'($urandom), (i == 34), 1'b0);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL long_m_valid beat=%0d got %0b exp 0", i, m_valid); end
      checks++; if (frame_err !== (i == N_FEAT - 1)) begin
        errors++; $display("FAIL long_frame_err beat=%0d got %0b exp %0b", i, frame_err, (i == N_FEAT - 1));
      end
      if (i == N_FEAT - 1) begin
        exp_err++;
        checks++; if (err_cnt !== ERR_CNT_W'(exp_err)) begin errors++; $display("FAIL long_err_cnt got %0d exp %0d", err_cnt, exp_err); end
      end
    end
    send_frame(d, 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL long_next_valid got %0b exp 1", m_valid); end
    checks++; if (m_feat !== ref_vec(d)) begin errors++; $display("FAIL long_next_vec got %h exp %h", m_feat, ref_vec(d)); end
    @(posedge clk); #1;
  endtask

  task automatic test_err_saturate();
    for (int n = 0; n < 260; n++) send_beat(RAW_W'($urandom), 1'b1, 1'b0);
    exp_err = 255;
    checks++; if (err_cnt !== ERR_CNT_W'(exp_err)) begin errors++; $display("FAIL sat_err_cnt got %0d exp %0d", err_cnt, exp_err); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL sat_m_valid got %0b exp 0", m_valid); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_quant_points();
    test_full_frame();
    test_stall();
    test_gaps();
    test_reset_mid();
`ifndef CYBERNID_LEN_CHECK_EN
    test_slast_ignored();
`else
    test_short_frame();
    test_long_frame();
    test_err_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
